word_byte_serializer: RTL



---
 rtl/word_byte_serializer_pkg.sv | 8 +
 rtl/word_byte_serializer_splitter.sv | 13 +
 rtl/word_byte_serializer.sv | 62 ++++++
 3 files changed

// File: rtl/word_byte_serializer_pkg.sv
// word_byte_serializer_pkg: state encoding and lane indices shared by the serializer files.
package word_byte_serializer_pkg;
    typedef enum logic {S_IDLE, S_SEND} state_t;
    localparam logic [1:0] LANE3 = 2'd3;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE0 = 2'd0;
endpackage

// File: rtl/word_byte_serializer_splitter.sv
// word_byte_serializer_splitter: decomposes a 32-bit word into its four byte lanes (o1 = lane3).
module word_byte_serializer_splitter (
    input  logic [31:0] word,
    output logic [7:0]  o1,
    output logic [7:0]  o2,
    output logic [7:0]  o3,
    output logic [7:0]  o4
);
    assign o1 = word[31:24];
    assign o2 = word[23:16];
    assign o3 = word[15:8];
    assign o4 = word[7:0];
endmodule

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: emits the enabled byte lanes of a word, MSB lane first, one per cycle.
module word_byte_serializer
    import word_byte_serializer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_be,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy
);
    function automatic logic [1:0] top_lane(input logic [3:0] m);
        return m[3] ? LANE3 : m[2] ? LANE2 : m[1] ? LANE1 : LANE0;
    endfunction

    function automatic logic one_hot(input logic [3:0] m);
        return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
    endfunction

    state_t      state;
    logic [31:0] word_q;
    logic [3:0]  rem_q;
    logic [1:0]  lane;
    logic [7:0]  b3, b2, b1, b0;
    logic        out_fire, in_fire;

    word_byte_serializer_splitter u_split (.word(word_q), .o1(b3), .o2(b2), .o3(b1), .o4(b0));

    always_comb begin
        lane      = top_lane(rem_q);
        out_valid = (state == S_SEND);
        busy      = out_valid;
        out_data  = (lane == LANE3) ? b3 : (lane == LANE2) ? b2 : (lane == LANE1) ? b1 : b0;
        out_last  = out_valid && one_hot(rem_q);
        out_fire  = out_valid && out_ready;
        // Ready during the last byte's handshake lets words stream without a bubble.
        in_ready  = (state == S_IDLE) || (out_fire && out_last);
        in_fire   = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            word_q <= 32'd0;
            rem_q  <= 4'd0;
        end else if (in_fire) begin
            if (in_be != 4'd0)
                word_q <= in_data;
            rem_q <= in_be;
            state <= (in_be != 4'd0) ? S_SEND : S_IDLE;
        end else if (out_fire) begin
            rem_q <= rem_q & ~(4'd1 << lane);
            if (out_last)
                state <= S_IDLE;
        end
    end
endmodule
